// File: rtl/riscv_if_queue_if.sv
// ============================================================================
// Module      : riscv_if_queue_if
// Description : Bundles the instruction-cache request/response signals, the
//               EX redirect and the decode-side queue head of riscv_if_queue.
//               master = the fetch queue, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_if_queue_if #(
    parameter int DEPTH = 4
);
    // Instruction-cache side
    logic                     icache_ren;
    logic [29:0]              icache_addr;
    logic [31:0]              icache_rdata;
    logic                     icache_stall;
    // Redirect from EX
    logic                     redirect;
    logic [31:0]              redirect_pc;
    // Decode side
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_inst;
    logic [31:0]              out_pc;
    logic [31:0]              out_pred_dest;
    logic                     out_pred_taken;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output icache_ren, icache_addr,
        input  icache_rdata, icache_stall,
        input  redirect, redirect_pc,
        output out_valid, out_inst, out_pc, out_pred_dest, out_pred_taken, count,
        input  out_ready
    );

    modport slave (
        input  icache_ren, icache_addr,
        output icache_rdata, icache_stall,
        output redirect, redirect_pc,
        input  out_valid, out_inst, out_pc, out_pred_dest, out_pred_taken, count,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/riscv_if_queue.sv
// ============================================================================
// Module      : riscv_if_queue
// Description : RISC-V instruction-fetch queue. A FETCH/FULL/DRAIN FSM issues
//               instruction-cache reads and pushes the returned words, with
//               their pc and predicted next pc, into a circular FIFO read by
//               decode. Redirects flush the queue; a redirect that lands on a
//               stalled access drains that access before restarting.
//               Optional macro IF_STATIC_PREDICT_EN: backward-taken /
//               forward-not-taken prediction of conditional branches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_if_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input wire              clk,
    input wire              rst_n,
    riscv_if_queue_if.master bus
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_ren;
    logic [31:0]          r_pc;
    logic [31:0]          r_drain_pc;
    logic [C_PTR_W-1:0]   r_wptr;
    logic [C_PTR_W-1:0]   r_rptr;
    logic [C_CNT_W-1:0]   r_count;

    logic [31:0]          r_mem_inst  [DEPTH];
    logic [31:0]          r_mem_pc    [DEPTH];
    logic [31:0]          r_mem_dest  [DEPTH];
    logic                 r_mem_taken [DEPTH];

    logic                 w_push;
    logic                 w_pop;
    logic                 w_valid;
    logic [C_CNT_W-1:0]   w_count_next;
    logic                 w_pred_taken;
    logic [31:0]          w_pred_dest;
    logic [31:0]          w_redirect_pc;

    // A completed access in DRAIN belongs to the flushed stream and is dropped
    assign w_push        = r_ren && !bus.icache_stall && (r_state == ST_FETCH);
    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid && bus.out_ready;
    assign w_count_next  = r_count + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
    assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};

`ifdef IF_STATIC_PREDICT_EN
    logic [31:0] w_bimm;
    // Sign-extended B-type immediate; a negative offset is a backward branch
    assign w_bimm       = {{19{bus.icache_rdata[31]}}, bus.icache_rdata[31], bus.icache_rdata[7],
                           bus.icache_rdata[30:25], bus.icache_rdata[11:8], 1'b0};
    assign w_pred_taken = (bus.icache_rdata[6:0] == 7'b1100011) && bus.icache_rdata[31];
    assign w_pred_dest  = w_pred_taken ? (r_pc + w_bimm) : (r_pc + 32'd4);
`else
    assign w_pred_taken = 1'b0;
    assign w_pred_dest  = r_pc + 32'd4;
`endif

    // Fetch FSM, fetch pc and queue pointers; redirect overrides push/pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_ren      <= 1'b0;
            r_pc       <= RESET_PC;
            r_drain_pc <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (bus.redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ren   <= 1'b1;
            if (r_ren && bus.icache_stall) begin
                // Access in flight: keep the address stable until it completes
                r_state    <= ST_DRAIN;
                r_drain_pc <= w_redirect_pc;
            end else begin
                r_state <= ST_FETCH;
                r_pc    <= w_redirect_pc;
            end
        end else begin
            case (r_state)
                ST_DRAIN: begin
                    if (!bus.icache_stall) begin
                        r_state <= ST_FETCH;
                        r_pc    <= r_drain_pc;
                        r_ren   <= 1'b1;
                    end
                end
                default: begin
                    if (w_push) begin
                        r_wptr <= r_wptr + 1'b1;
                        r_pc   <= w_pred_dest;
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                    r_count <= w_count_next;
                    // Request is registered off the next occupancy so it never overfills
                    if (w_count_next == C_FULL) begin
                        r_state <= ST_FULL;
                        r_ren   <= 1'b0;
                    end else begin
                        r_state <= ST_FETCH;
                        r_ren   <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Queue storage write; contents need no reset because count gates the head
    always_ff @(posedge clk) begin
        if (rst_n && !bus.redirect && w_push) begin
            r_mem_inst[r_wptr]  <= bus.icache_rdata;
            r_mem_pc[r_wptr]    <= r_pc;
            r_mem_dest[r_wptr]  <= w_pred_dest;
            r_mem_taken[r_wptr] <= w_pred_taken;
        end
    end

    assign bus.icache_ren     = r_ren;
    assign bus.icache_addr    = r_pc[31:2];
    assign bus.count          = r_count;
    assign bus.out_valid      = w_valid;
    assign bus.out_inst       = w_valid ? r_mem_inst[r_rptr]  : 32'd0;
    assign bus.out_pc         = w_valid ? r_mem_pc[r_rptr]    : 32'd0;
    assign bus.out_pred_dest  = w_valid ? r_mem_dest[r_rptr]  : 32'd0;
    assign bus.out_pred_taken = w_valid ? r_mem_taken[r_rptr] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_riscv_if_queue.sv
// ============================================================================
// Module      : tb_riscv_if_queue
// Description : Directed self-checking bench for riscv_if_queue (DEPTH=4,
//               RESET_PC=0). The cache model returns {word_addr, 2'b11}, or a
//               backward beq at pc 0x40 when branch_mode is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_if_queue;

    logic clk;
    logic rst_n;
    logic branch_mode;
    int   n_checks;
    int   n_fail;

    riscv_if_queue_if #(.DEPTH(4)) bus ();

    riscv_if_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction-cache data model
    always_comb begin
        bus.icache_rdata = {bus.icache_addr, 2'b11};
        if (branch_mode && bus.icache_addr == 30'h10)
            bus.icache_rdata = 32'hFE00_08E3;   // beq x0,x0,-16
    end

    // Advance one cycle and settle just after the rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles, then one running edge: request up at RESET_PC, queue empty
    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.icache_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren got %0b exp 0", bus.icache_ren); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", bus.out_valid); end
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        n_checks++; if ({bus.out_inst, bus.out_pc, bus.out_pred_dest, bus.out_pred_taken} !== 97'd0) begin
            n_fail++; $display("FAIL reset_outs got inst=%h pc=%h dest=%h tk=%0b exp all 0",
                               bus.out_inst, bus.out_pc, bus.out_pred_dest, bus.out_pred_taken); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.icache_ren !== 1'b1) begin n_fail++; $display("FAIL release_ren got %0b exp 1", bus.icache_ren); end
        n_checks++; if (bus.icache_addr !== 30'h0) begin n_fail++; $display("FAIL release_addr got %h exp 0", bus.icache_addr); end
    endtask

    task automatic test_stream;
        bus.out_ready = 1'b1;
        do_reset();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_prefetch_valid got %0b exp 0", bus.out_valid); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i)) begin
                n_fail++; $display("FAIL stream_pc[%0d] got v=%0b pc=%h exp v=1 pc=%h", i, bus.out_valid, bus.out_pc, 4 * i); end
            n_checks++; if (bus.out_inst !== 32'(4 * i + 3) || bus.out_pred_dest !== 32'(4 * i + 4)) begin
                n_fail++; $display("FAIL stream_data[%0d] got inst=%h dest=%h exp inst=%h dest=%h",
                                   i, bus.out_inst, bus.out_pred_dest, 4 * i + 3, 4 * i + 4); end
            n_checks++; if (bus.icache_addr !== 30'(i + 1) || bus.count !== 3'd1) begin
                n_fail++; $display("FAIL stream_addr[%0d] got addr=%h cnt=%0d exp addr=%h cnt=1", i, bus.icache_addr, bus.count, i + 1); end
        end
    endtask

    task automatic test_full;
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (bus.count !== 3'd4 || bus.icache_ren !== 1'b0) begin
            n_fail++; $display("FAIL full_reach got cnt=%0d ren=%0b exp cnt=4 ren=0", bus.count, bus.icache_ren); end
        tick();
        n_checks++; if (bus.count !== 3'd4 || bus.icache_ren !== 1'b0 || bus.out_pc !== 32'h0) begin
            n_fail++; $display("FAIL full_hold got cnt=%0d ren=%0b pc=%h exp cnt=4 ren=0 pc=0", bus.count, bus.icache_ren, bus.out_pc); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++; if (bus.count !== 3'd3 || bus.icache_ren !== 1'b1 || bus.icache_addr !== 30'h4 || bus.out_pc !== 32'h4) begin
            n_fail++; $display("FAIL full_pop got cnt=%0d ren=%0b addr=%h pc=%h exp cnt=3 ren=1 addr=4 pc=4",
                               bus.count, bus.icache_ren, bus.icache_addr, bus.out_pc); end
        tick();
        n_checks++; if (bus.count !== 3'd4 || bus.icache_ren !== 1'b0) begin
            n_fail++; $display("FAIL full_refill got cnt=%0d ren=%0b exp cnt=4 ren=0", bus.count, bus.icache_ren); end
    endtask

    task automatic test_redirect;
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count got %0d exp 3", bus.count); end
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_1002;
        tick();
        bus.redirect = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.icache_addr !== 30'h400) begin
            n_fail++; $display("FAIL redir_flush got v=%0b cnt=%0d addr=%h exp v=0 cnt=0 addr=400", bus.out_valid, bus.count, bus.icache_addr); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1000 || bus.count !== 3'd1) begin
            n_fail++; $display("FAIL redir_first got v=%0b pc=%h cnt=%0d exp v=1 pc=1000 cnt=1", bus.out_valid, bus.out_pc, bus.count); end
    endtask

    task automatic test_redirect_stall;
        bus.out_ready = 1'b1;
        do_reset();
        tick();
        bus.icache_stall = 1'b1;
        bus.redirect     = 1'b1;
        bus.redirect_pc  = 32'h0000_0200;
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.icache_addr !== 30'h1 || bus.icache_ren !== 1'b1 || bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL drain_hold[%0d] got addr=%h ren=%0b cnt=%0d v=%0b exp addr=1 ren=1 cnt=0 v=0",
                                   i, bus.icache_addr, bus.icache_ren, bus.count, bus.out_valid); end
            if (i == 2) bus.icache_stall = 1'b0;
            tick();
        end
        n_checks++; if (bus.icache_addr !== 30'h80 || bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_resume got addr=%h cnt=%0d v=%0b exp addr=80 cnt=0 v=0", bus.icache_addr, bus.count, bus.out_valid); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200) begin
            n_fail++; $display("FAIL drain_first got v=%0b pc=%h exp v=1 pc=200", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_drain_redirect;
        bus.out_ready = 1'b0;
        do_reset();
        bus.icache_stall = 1'b1;
        bus.redirect     = 1'b1;
        bus.redirect_pc  = 32'h0000_0200;
        tick();
        bus.redirect_pc  = 32'h0000_0300;
        tick();
        bus.redirect     = 1'b0;
        bus.icache_stall = 1'b0;
        n_checks++; if (bus.icache_addr !== 30'h0) begin n_fail++; $display("FAIL drain2_hold got addr=%h exp 0", bus.icache_addr); end
        tick();
        n_checks++; if (bus.icache_addr !== 30'hC0 || bus.count !== 3'd0) begin
            n_fail++; $display("FAIL drain2_resume got addr=%h cnt=%0d exp addr=c0 cnt=0", bus.icache_addr, bus.count); end
    endtask

    task automatic test_reset_in_drain;
        bus.out_ready = 1'b1;
        do_reset();
        tick();
        bus.icache_stall = 1'b1;
        bus.redirect     = 1'b1;
        bus.redirect_pc  = 32'h0000_0500;
        tick();
        bus.redirect = 1'b0;
        rst_n = 1'b0;
        tick();
        n_checks++; if (bus.icache_ren !== 1'b0 || bus.count !== 3'd0) begin
            n_fail++; $display("FAIL rstdrain_state got ren=%0b cnt=%0d exp ren=0 cnt=0", bus.icache_ren, bus.count); end
        rst_n = 1'b1;
        bus.icache_stall = 1'b0;
        tick();
        n_checks++; if (bus.icache_ren !== 1'b1 || bus.icache_addr !== 30'h0) begin
            n_fail++; $display("FAIL rstdrain_restart got ren=%0b addr=%h exp ren=1 addr=0", bus.icache_ren, bus.icache_addr); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.icache_addr !== 30'h1) begin
            n_fail++; $display("FAIL rstdrain_fetch got v=%0b pc=%h addr=%h exp v=1 pc=0 addr=1", bus.out_valid, bus.out_pc, bus.icache_addr); end
    endtask

    task automatic test_predict;
        logic        exp_taken;
        logic [31:0] exp_dest;
        logic [29:0] exp_addr;
`ifdef IF_STATIC_PREDICT_EN
        exp_taken = 1'b1; exp_dest = 32'h30; exp_addr = 30'h0C;
`else
        exp_taken = 1'b0; exp_dest = 32'h44; exp_addr = 30'h11;
`endif
        bus.out_ready = 1'b1;
        do_reset();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        tick();
        bus.redirect = 1'b0;
        branch_mode  = 1'b1;
        n_checks++; if (bus.icache_addr !== 30'h10) begin n_fail++; $display("FAIL pred_addr got %h exp 10", bus.icache_addr); end
        tick();
        branch_mode = 1'b0;
        n_checks++; if (bus.out_pc !== 32'h40 || bus.out_inst !== 32'hFE00_08E3) begin
            n_fail++; $display("FAIL pred_head got pc=%h inst=%h exp pc=40 inst=fe0008e3", bus.out_pc, bus.out_inst); end
        n_checks++; if (bus.out_pred_taken !== exp_taken || bus.out_pred_dest !== exp_dest) begin
            n_fail++; $display("FAIL pred_out got tk=%0b dest=%h exp tk=%0b dest=%h", bus.out_pred_taken, bus.out_pred_dest, exp_taken, exp_dest); end
        n_checks++; if (bus.icache_addr !== exp_addr) begin
            n_fail++; $display("FAIL pred_next got addr=%h exp %h", bus.icache_addr, exp_addr); end
    endtask

    // Test sequence
    initial begin
        n_checks         = 0;
        n_fail           = 0;
        branch_mode      = 1'b0;
        rst_n            = 1'b0;
        bus.icache_stall = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'h0;
        bus.out_ready    = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_stall();
        test_drain_redirect();
        test_reset_in_drain();
        test_predict();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Run-time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/riscv_if_queue.md
RISCV_IF_QUEUE -- requirements
Module: riscv_if_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning fetch-queue entries; legal values 2, 4, 8.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 icache_ren  output  1  instruction-cache read request.
REQ-006 icache_addr  output  30  word address of the request (fetch pc[31:2]).
REQ-007 icache_rdata  input  32  instruction word; valid in any cycle with icache_ren=1 and icache_stall=0.
REQ-008 icache_stall  input  1  cache busy; the access is held while high.
REQ-009 redirect  input  1  correction from EX; flushes the queue and restarts fetch.
REQ-010 redirect_pc  input  32  restart address; bits [1:0] are ignored and treated as 0.
REQ-011 out_valid  output  1  queue head holds an instruction.
REQ-012 out_ready  input  1  decode accepts the head; the pop happens when out_valid and out_ready are both 1.
REQ-013 out_inst, out_pc, out_pred_dest  output  32 each  head instruction, its pc, and its predicted next pc.
REQ-014 out_pred_taken  output  1  head was predicted taken.
REQ-015 count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 SHALL implement a circular FIFO of DEPTH entries, each holding {inst, pc, pred_taken, pred_dest}.
- Read and write pointers wrap modulo DEPTH.
- count ranges 0..DEPTH.
REQ-017 The fetch FSM SHALL have three states:
- FETCH: icache_ren=1 while count < DEPTH.
- FULL: icache_ren=0; moves to FETCH in the cycle after count drops below DEPTH.
- DRAIN: icache_ren=1 with the old address; the returned data is discarded.
REQ-018 A fetch SHALL complete in any cycle where icache_ren=1 and icache_stall=0.
- The entry is pushed at that edge.
- out_valid for it is 1 in the next cycle, so fetch-to-decode latency is 1 cycle.
REQ-019 With icache_stall=0 and out_ready=1, SHALL sustain one instruction per cycle.
REQ-020 icache_addr SHALL stay stable while icache_stall=1.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged.
- At count=DEPTH no push occurs, because icache_ren=0.
REQ-022 Next fetch pc after a completed fetch SHALL be pred_dest, otherwise pc+4; the pc wraps modulo 2^32.
REQ-023 On a redirect while icache_stall=0 or icache_ren=0:
- the queue is emptied at that edge and out_valid=0 next cycle;
- any same-cycle push and pop are cancelled;
- fetch restarts at redirect_pc, in FETCH.
REQ-024 On a redirect while icache_ren=1 and icache_stall=1:
- the queue is emptied and redirect_pc is latched;
- the FSM enters DRAIN;
- when the stall ends, the data is dropped and fetch resumes at the latched pc in the next cycle.
REQ-025 A second redirect during DRAIN SHALL overwrite the latched pc.
REQ-026 Redirect SHALL take priority over push, pop and prediction.

Reset
REQ-027 While rst_n=0 at a clock edge:
- fetch pc=RESET_PC, queue empty, count=0, FSM=FETCH;
- icache_ren=0, out_valid=0, and out_inst/out_pc/out_pred_dest/out_pred_taken all 0.
REQ-028 icache_ren SHALL rise in the first cycle after rst_n goes high, with icache_addr=RESET_PC[31:2].
REQ-029 Reset mid-access (including DRAIN) SHALL abandon the access and discard any latched redirect.

Configuration
REQ-030 Macro IF_STATIC_PREDICT_EN enables backward-taken/forward-not-taken prediction.
- Defined: if inst[6:0]=7'b1100011 and the B-immediate is negative, then pred_taken=1 and pred_dest=pc+imm.
- Otherwise pred_taken=0 and pred_dest=pc+4.
REQ-031 Without IF_STATIC_PREDICT_EN: pred_taken=0 and pred_dest=pc+4 always; no immediate logic is built.

Verification
REQ-032 Reset release, cache never stalls, out_ready=1 -> addresses 0,1,2,...; out_pc 0x0,0x4,0x8 one per cycle, starting one cycle after the first fetch.
REQ-033 DEPTH=4, out_ready=0 -> count reaches 4, icache_ren=0; raise out_ready for one cycle -> one pop, icache_ren=1 next cycle, count returns to 4.
REQ-034 Redirect to 0x0000_1002 with no stall, queue holding 3 entries -> next cycle out_valid=0, count=0, icache_addr=0x400.
REQ-035 Redirect to 0x200 while icache_stall=1 for 3 more cycles -> address held; stale word not enqueued; then icache_addr=0x80.
REQ-036 IF_STATIC_PREDICT_EN, beq at pc 0x40 with imm=-16 -> out_pred_taken=1, out_pred_dest=0x30, next icache_addr=0x0C; same stimulus without the macro -> out_pred_taken=0, next icache_addr=0x11.
